aes_spi_sequencer: RTL and testbench

AES_SPI_SEQUENCER -- requirements
Module: aes_spi_sequencer

---
 rtl/aes_spi_sequencer.sv | 149 ++++++++++++++
 tb/tb_aes_spi_sequencer.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_spi_sequencer.sv
// AES-over-SPI byte sequencer: streams block, key length and key to
// an SPI master byte by byte, then collects the 16-byte result.
module aes_spi_sequencer #(
  parameter int GAP_CYCLES = 2,
  parameter int TIMEOUT    = 1024
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         go,
  input  logic [7:0]   key_size,
  input  logic [127:0] block_in,
  input  logic [255:0] key_in,
  output logic         spi_start,
  output logic [7:0]   spi_tx,
  input  logic [7:0]   spi_rx,
  input  logic         spi_busy,
  input  logic         spi_done,
  output logic         busy,
  output logic [127:0] result,
  output logic         result_valid,
  output logic         error
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_GAP   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]   state;
  logic [127:0] blk_sh;
  logic [255:0] key_sh;
  logic [7:0]   k_r;
  logic [6:0]   n;
  logic [31:0]  wcnt;
  logic [31:0]  gcnt;

  logic         key_ok;
  logic [7:0]   n_ext;
  logic [7:0]   n_next;
  logic [7:0]   frame_len;
  logic         rx_phase;
  logic         key_phase;
  logic [7:0]   tx_byte;
  logic [8:0]   key_shamt;

  assign busy      = (state != S_IDLE);
  assign key_ok    = (key_size == 8'd16) || (key_size == 8'd24) ||
                     (key_size == 8'd32);
  assign n_ext     = {1'b0, n};
  assign n_next    = n_ext + 8'd1;
  assign frame_len = 8'd33 + k_r;
  assign rx_phase  = (n_ext >= (8'd17 + k_r));
  assign key_phase = (n_ext > 8'd16) && !rx_phase;
  // Left-align the used key bytes so the top byte is always next out
  assign key_shamt = {6'd32 - key_size[5:0], 3'b000};

  // Select the byte for the current transfer index
  always_comb begin
    tx_byte = 8'h00;
    if (n_ext < 8'd16)
      tx_byte = blk_sh[127:120];
    else if (n_ext == 8'd16)
      tx_byte = k_r;
    else if (key_phase)
      tx_byte = key_sh[255:248];
  end

  // Frame sequencing FSM with byte issue, timeout and inter-byte gap
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      blk_sh       <= '0;
      key_sh       <= '0;
      k_r          <= '0;
      n            <= '0;
      wcnt         <= '0;
      gcnt         <= '0;
      spi_start    <= 1'b0;
      spi_tx       <= 8'h00;
      result       <= '0;
      result_valid <= 1'b0;
      error        <= 1'b0;
    end else begin
      spi_start    <= 1'b0;
      result_valid <= 1'b0;
      error        <= 1'b0;
      case (state)
        S_IDLE: begin
          if (go) begin
            if (key_ok) begin
              blk_sh <= block_in;
              key_sh <= key_in << key_shamt;
              k_r    <= key_size;
              result <= '0;
              n      <= '0;
              state  <= S_ISSUE;
            end else begin
              error <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          if (!spi_busy) begin
            spi_tx    <= tx_byte;
            spi_start <= 1'b1;
            wcnt      <= '0;
            state     <= S_WAIT;
            if (n_ext < 8'd16)
              blk_sh <= blk_sh << 8;
            else if (key_phase)
              key_sh <= key_sh << 8;
          end
        end
        S_WAIT: begin
          if (spi_done) begin
            if (rx_phase)
              result <= {result[119:0], spi_rx};
            n <= n_next[6:0];
            if (n_next == frame_len) begin
              result_valid <= 1'b1;
              state        <= S_DONE;
            end else if (GAP_CYCLES == 0) begin
              state <= S_ISSUE;
            end else begin
              gcnt  <= '0;
              state <= S_GAP;
            end
          end else if (wcnt == 32'(TIMEOUT - 1)) begin
            error  <= 1'b1;
            result <= '0;
            state  <= S_IDLE;
          end else begin
            wcnt <= wcnt + 32'd1;
          end
        end
        S_GAP: begin
          if (gcnt == 32'(GAP_CYCLES - 1))
            state <= S_ISSUE;
          else
            gcnt <= gcnt + 32'd1;
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_spi_sequencer.sv
// Self-checking bench for aes_spi_sequencer: SPI slave model,
// frame reference model and directed/random frames.
module tb_aes_spi_sequencer;

  localparam int GAP = 2;
  localparam int TMO = 1024;

  logic         clk = 1'b0;
  logic         reset;
  logic         go;
  logic [7:0]   key_size;
  logic [127:0] block_in;
  logic [255:0] key_in;
  logic         spi_start;
  logic [7:0]   spi_tx;
  logic [7:0]   spi_rx;
  logic         spi_busy;
  logic         spi_done;
  logic         busy;
  logic [127:0] result;
  logic         result_valid;
  logic         error;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0]   tx_q[$];
  int           frame_n = 65;
  int           hold_idx = -1;
  int           stop_idx = -1;
  logic [127:0] resp = '0;
  int           vcnt = 0;
  int           ecnt = 0;
  int           err_cyc = 0;
  int           stop_cyc = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  aes_spi_sequencer #(.GAP_CYCLES(GAP), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .go(go), .key_size(key_size),
    .block_in(block_in), .key_in(key_in), .spi_start(spi_start),
    .spi_tx(spi_tx), .spi_rx(spi_rx), .spi_busy(spi_busy),
    .spi_done(spi_done), .busy(busy), .result(result),
    .result_valid(result_valid), .error(error)
  );

  task automatic chk(input string tag, input logic [255:0] obs,
                     input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pulse counters for result_valid and error
  initial forever begin
    @(negedge clk);
    if (result_valid === 1'b1) vcnt++;
    if (error === 1'b1) begin
      ecnt++;
      err_cyc = cyc;
    end
  end

  // SPI slave model: random latency, optional extra busy, optional stall
  initial begin
    int cd = 0;
    int hold = 0;
    int last_done = 0;
    int cur = 0;
    int r;
    bit hpend = 0;
    bit last_hold = 0;
    spi_busy = 1'b0;
    spi_done = 1'b0;
    spi_rx   = 8'h00;
    forever begin
      @(negedge clk);
      if (reset === 1'b1) begin
        cd = 0; hold = 0; hpend = 0;
        spi_busy = 1'b0;
        spi_done = 1'b0;
        chk("start_in_reset", spi_start, 0);
      end else begin
        if (spi_done) begin
          spi_done = 1'b0;
          if (hpend) begin
            hold = 7;
            hpend = 0;
          end else begin
            spi_busy = 1'b0;
          end
        end else if (hold > 0) begin
          hold--;
          if (hold == 0) spi_busy = 1'b0;
        end
        if (cd > 0) begin
          cd--;
          if (cd == 0) begin
            spi_done = 1'b1;
            if (cur >= frame_n - 16) begin
              r = 15 - (cur - (frame_n - 16));
              spi_rx = resp[8*r +: 8];
            end else begin
              spi_rx = 8'($urandom);
            end
            last_done = cyc;
            last_hold = (cur == hold_idx);
            hpend = last_hold;
          end
        end
        if (spi_start === 1'b1) begin
          chk("start_while_busy", spi_busy, 0);
          if (tx_q.size() > 0)
            chk("gap_cycles", cyc - last_done,
                (last_hold ? ((GAP > 7) ? GAP : 7) : GAP) + 2);
          cur = tx_q.size();
          tx_q.push_back(spi_tx);
          if (cur == stop_idx) begin
            stop_cyc = cyc;
          end else begin
            spi_busy = 1'b1;
            cd = $urandom_range(1, 4);
          end
        end
      end
    end
  end

  // Reference frame: block bytes MSB first, K, used key bytes MSB first, zeros
  task automatic build_frame(input logic [7:0] k, input logic [127:0] blk,
                             input logic [255:0] key,
                             output logic [7:0] q[$]);
    q.delete();
    for (int i = 0; i < 16; i++) q.push_back(blk[8*(15-i) +: 8]);
    q.push_back(k);
    for (int j = 0; j < int'(k); j++) q.push_back(key[8*(int'(k)-1-j) +: 8]);
    for (int i = 0; i < 16; i++) q.push_back(8'h00);
  endtask

  task automatic start_go(input logic [7:0] k, input logic [127:0] blk,
                          input logic [255:0] key);
    @(negedge clk);
    key_size = k; block_in = blk; key_in = key; go = 1'b1;
    @(negedge clk);
    go = 1'b0;
  endtask

  task automatic run_frame(input string nm, input logic [7:0] k,
                           input logic [127:0] blk, input logic [255:0] key,
                           input logic [127:0] rsp, input int hidx,
                           input bit midgo);
    logic [7:0] exp_q[$];
    int nb;
    build_frame(k, blk, key, exp_q);
    nb = exp_q.size();
    frame_n = nb; resp = rsp; hold_idx = hidx; stop_idx = -1;
    tx_q.delete(); vcnt = 0; ecnt = 0;
    start_go(k, blk, key);
    chk({nm, "_busy_go"}, busy, 1);
    key_size = 8'($urandom);
    block_in = {$urandom, $urandom, $urandom, $urandom};
    key_in = ~key;
    for (int c = 0; c < 20000 && vcnt == 0 && ecnt == 0; c++) begin
      @(negedge clk);
      go = (midgo && c == 100);
    end
    go = 1'b0;
    chk({nm, "_valid"}, vcnt, 1);
    chk({nm, "_noerr"}, ecnt, 0);
    chk({nm, "_result"}, result, rsp);
    repeat (3) @(negedge clk);
    chk({nm, "_idle"}, busy, 0);
    chk({nm, "_valid_once"}, vcnt, 1);
    chk({nm, "_count"}, tx_q.size(), nb);
    for (int i = 0; i < nb && i < tx_q.size(); i++)
      chk({nm, "_tx"}, tx_q[i], exp_q[i]);
  endtask

  initial begin
    logic [127:0] blk0;
    logic [255:0] key0;
    logic [127:0] rsp0;
    logic [7:0]   bad_k[3];
    logic [7:0]   k;
    int           sz;
    blk0 = 128'h00112233445566778899aabbccddeeff;
    key0 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    rsp0 = 128'h8ea2b7ca516745bfeafc49904b496089;
    bad_k[0] = 8'd20; bad_k[1] = 8'd0; bad_k[2] = 8'd255;

    reset = 1'b1; go = 1'b0; key_size = 8'd0;
    block_in = '0; key_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_start", spi_start, 0);
    chk("rst_tx", spi_tx, 0);
    chk("rst_result", result, 0);
    chk("rst_valid", result_valid, 0);
    chk("rst_error", error, 0);
    #1 reset = 1'b0;

    run_frame("k32", 8'd32, blk0, key0, rsp0, -1, 1'b0);
    run_frame("k16", 8'd16, blk0, key0, rsp0, -1, 1'b0);

    foreach (bad_k[i]) begin
      tx_q.delete(); ecnt = 0;
      @(negedge clk);
      key_size = bad_k[i]; go = 1'b1;
      @(negedge clk);
      go = 1'b0;
      chk("badk_error", error, 1);
      chk("badk_busy", busy, 0);
      @(negedge clk);
      chk("badk_err_pulse", error, 0);
      repeat (5) @(negedge clk);
      chk("badk_nostart", tx_q.size(), 0);
      chk("badk_err_count", ecnt, 1);
    end

    frame_n = 65; resp = rsp0; hold_idx = -1; stop_idx = 5;
    tx_q.delete(); vcnt = 0; ecnt = 0;
    start_go(8'd32, blk0, key0);
    for (int c = 0; c < TMO + 1000 && ecnt == 0; c++) @(negedge clk);
    chk("tmo_error", ecnt, 1);
    chk("tmo_latency", err_cyc - stop_cyc, TMO);
    @(negedge clk);
    chk("tmo_result", result, 0);
    chk("tmo_idle", busy, 0);
    chk("tmo_novalid", vcnt, 0);
    chk("tmo_count", tx_q.size(), 6);
    stop_idx = -1;

    frame_n = 65; tx_q.delete(); vcnt = 0; ecnt = 0;
    start_go(8'd32, blk0, key0);
    for (int c = 0; c < 5000 && tx_q.size() < 31; c++) @(negedge clk);
    #1 reset = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("mid_rst_start", spi_start, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_result", result, 0);
      chk("mid_rst_tx", spi_tx, 0);
    end
    #1 reset = 1'b0;
    sz = tx_q.size();
    chk("mid_rst_bytes", sz, 31);
    repeat (10) @(negedge clk);
    chk("mid_rst_nomore", tx_q.size(), sz);
    chk("mid_rst_novalid", vcnt, 0);
    run_frame("after_rst", 8'd32, blk0, key0, rsp0, -1, 1'b0);

    run_frame("hold_midgo", 8'd24, blk0, key0, rsp0, 10, 1'b1);

    for (int t = 0; t < 3; t++) begin
      k = 8'(16 + 8 * $urandom_range(0, 2));
      run_frame("rand", k, {$urandom, $urandom, $urandom, $urandom},
                {$urandom, $urandom, $urandom, $urandom,
                 $urandom, $urandom, $urandom, $urandom},
                {$urandom, $urandom, $urandom, $urandom},
                $urandom_range(0, 40), 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
